// File: rtl/cdb_broadcast.sv
// cdb_broadcast: per-FU result FIFOs feeding the common data bus.
// Each FU deposits tag+data into its own small FIFO and requests the bus
// while entries are pending. The arbiter's one-hot grant pops one head,
// which appears on the registered CDB outputs one cycle later.
module cdb_broadcast #(
   parameter int NUM_FU = 3,
   parameter int XLEN   = 32,
   parameter int TAG_W  = 4,
   parameter int DEPTH  = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    stall_i,
   input  logic                    flush_i,
   input  logic [NUM_FU-1:0]       fu_valid_i,
   input  logic [NUM_FU*TAG_W-1:0] fu_tag_i,
   input  logic [NUM_FU*XLEN-1:0]  fu_data_i,
   output logic [NUM_FU-1:0]       fu_ready_o,
   output logic [NUM_FU-1:0]       cdb_req,
   input  logic [NUM_FU-1:0]       fu_sel,
   output logic                    cdb_valid_o,
   output logic [TAG_W-1:0]        cdb_tag_o,
   output logic [XLEN-1:0]         cdb_data_o,
   output logic                    sel_err_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [XLEN-1:0]  data;
   } entry_t;

   entry_t           mem_q    [NUM_FU][DEPTH];
   logic [PTR_W-1:0] wr_ptr_q [NUM_FU];
   logic [PTR_W-1:0] wr_ptr_d [NUM_FU];
   logic [PTR_W-1:0] rd_ptr_q [NUM_FU];
   logic [PTR_W-1:0] rd_ptr_d [NUM_FU];
   logic [CNT_W-1:0] count_q  [NUM_FU];
   logic [CNT_W-1:0] count_d  [NUM_FU];

   logic [NUM_FU-1:0] push;
   logic [NUM_FU-1:0] grant;
   logic [NUM_FU-1:0] pop;
   logic [IDX_W-1:0]  sel_idx;
   entry_t            head;

   logic              cdb_valid_q, cdb_valid_d;
   logic [TAG_W-1:0]  cdb_tag_q,   cdb_tag_d;
   logic [XLEN-1:0]   cdb_data_q,  cdb_data_d;
   logic              sel_err_q,   sel_err_d;

   // Occupancy status: ready while not full, request while not empty.
   always_comb begin
      for (int i = 0; i < NUM_FU; i++) begin
         fu_ready_o[i] = (count_q[i] != FULL);
         cdb_req[i]    = (count_q[i] != '0);
      end
   end

   // Grant qualification, lowest-index pop select, error and broadcast next state.
   always_comb begin
      // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latch).
      grant   = stall_i ? '0 : (fu_sel & cdb_req);
      pop     = grant & (~grant + NUM_FU'(1));
      sel_idx = '0;
      for (int i = NUM_FU - 1; i >= 0; i--) begin
         if (grant[i]) sel_idx = IDX_W'(i);
      end
      head = mem_q[sel_idx][rd_ptr_q[sel_idx]];

      sel_err_d = !stall_i &&
                  ((|(fu_sel & (fu_sel - NUM_FU'(1)))) || (|(fu_sel & ~cdb_req)));

      cdb_valid_d = !flush_i && (|pop);
      cdb_tag_d   = cdb_tag_q;
      cdb_data_d  = cdb_data_q;
      if (cdb_valid_d) begin
         cdb_tag_d  = head.tag;
         cdb_data_d = head.data;
      end
   end

   // FIFO pointer and count next state; flush empties everything.
   always_comb begin
      for (int i = 0; i < NUM_FU; i++) begin
         push[i]     = fu_valid_i[i] && fu_ready_o[i] && !flush_i;
         wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(push[i]);
         rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(pop[i]);
         count_d[i]  = count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
         if (flush_i) begin
            wr_ptr_d[i] = '0;
            rd_ptr_d[i] = '0;
            count_d[i]  = '0;
         end
      end
   end

   // Control state and registered CDB outputs.
   always_ff @(posedge clk) begin
      // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
      if (rst) begin
         for (int i = 0; i < NUM_FU; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            count_q[i]  <= '0;
         end
         cdb_valid_q <= 1'b0;
         cdb_tag_q   <= '0;
         cdb_data_q  <= '0;
         sel_err_q   <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_FU; i++) begin
            wr_ptr_q[i] <= wr_ptr_d[i];
            rd_ptr_q[i] <= rd_ptr_d[i];
            count_q[i]  <= count_d[i];
         end
         cdb_valid_q <= cdb_valid_d;
         cdb_tag_q   <= cdb_tag_d;
         cdb_data_q  <= cdb_data_d;
         sel_err_q   <= sel_err_d;
      end
   end

   // Payload storage written on push.
   always_ff @(posedge clk) begin
      // NOTE: payload RAM is not reset; pointers and counts alone decide which entries are live.
      for (int i = 0; i < NUM_FU; i++) begin
         if (push[i]) begin
            mem_q[i][wr_ptr_q[i]] <= '{tag:  fu_tag_i[i*TAG_W +: TAG_W],
                                       data: fu_data_i[i*XLEN +: XLEN]};
         end
      end
   end

   assign cdb_valid_o = cdb_valid_q;
   assign cdb_tag_o   = cdb_tag_q;
   assign cdb_data_o  = cdb_data_q;
   assign sel_err_o   = sel_err_q;

   // Occupancy never exceeds DEPTH and a pop never hits an empty FIFO.
   for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_chk
      a_no_overflow:  assert property (@(posedge clk) disable iff (rst) count_q[gi] <= FULL);
      a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop[gi] && count_q[gi] == '0));
   end

endmodule

// File: tb/tb_cdb_broadcast.sv
// tb_cdb_broadcast: directed plan followed by random traffic, all checked
// against a queue-based model of the result buffers and the broadcast rules.
module tb_cdb_broadcast;

   localparam int NUM_FU = 3;
   localparam int XLEN   = 32;
   localparam int TAG_W  = 4;
   localparam int DEPTH  = 2;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    stall_i;
   logic                    flush_i;
   logic [NUM_FU-1:0]       fu_valid_i;
   logic [NUM_FU*TAG_W-1:0] fu_tag_i;
   logic [NUM_FU*XLEN-1:0]  fu_data_i;
   logic [NUM_FU-1:0]       fu_ready_o;
   logic [NUM_FU-1:0]       cdb_req;
   logic [NUM_FU-1:0]       fu_sel;
   logic                    cdb_valid_o;
   logic [TAG_W-1:0]        cdb_tag_o;
   logic [XLEN-1:0]         cdb_data_o;
   logic                    sel_err_o;

   cdb_broadcast #(.NUM_FU(NUM_FU), .XLEN(XLEN), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
      .fu_valid_i(fu_valid_i), .fu_tag_i(fu_tag_i), .fu_data_i(fu_data_i),
      .fu_ready_o(fu_ready_o), .cdb_req(cdb_req), .fu_sel(fu_sel),
      .cdb_valid_o(cdb_valid_o), .cdb_tag_o(cdb_tag_o), .cdb_data_o(cdb_data_o),
      .sel_err_o(sel_err_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [XLEN-1:0]  data;
   } entry_t;

   entry_t           q [NUM_FU][$];
   logic             exp_valid;
   logic [TAG_W-1:0] exp_tag;
   logic [XLEN-1:0]  exp_data;
   logic             exp_err;
   int               n_checks = 0;
   int               n_fails  = 0;

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
      end
   endtask

   function automatic logic [NUM_FU-1:0] model_req();
      logic [NUM_FU-1:0] r;
      for (int i = 0; i < NUM_FU; i++) r[i] = (q[i].size() != 0);
      return r;
   endfunction

   task automatic set_fu(input int i, input logic [TAG_W-1:0] t, input logic [XLEN-1:0] d);
      fu_tag_i[i*TAG_W +: TAG_W] = t;
      fu_data_i[i*XLEN +: XLEN]  = d;
   endtask

   // One clock: check request/ready against the model, advance the model by
   // the buffer rules, clock the DUT, then check the registered outputs.
   task automatic step();
      logic [NUM_FU-1:0] req, rdy, g;
      int                idx;
      entry_t            e;
      req = model_req();
      for (int i = 0; i < NUM_FU; i++) rdy[i] = (q[i].size() != DEPTH);
      check("cdb_req", cdb_req, req);
      check("fu_ready", fu_ready_o, rdy);

      if (rst) begin
         for (int i = 0; i < NUM_FU; i++) q[i].delete();
         exp_valid = 1'b0;
         exp_tag   = '0;
         exp_data  = '0;
         exp_err   = 1'b0;
      end else begin
         idx = -1;
         if (stall_i) begin
            exp_err = 1'b0;
         end else begin
            g       = fu_sel & req;
            exp_err = ($countones(fu_sel) > 1) || ((fu_sel & ~req) != 0);
            for (int i = NUM_FU - 1; i >= 0; i--) if (g[i]) idx = i;
         end
         if (flush_i) begin
            for (int i = 0; i < NUM_FU; i++) q[i].delete();
            exp_valid = 1'b0;
         end else begin
            exp_valid = (idx >= 0);
            if (idx >= 0) begin
               e        = q[idx].pop_front();
               exp_tag  = e.tag;
               exp_data = e.data;
            end
            for (int i = 0; i < NUM_FU; i++) begin
               if (fu_valid_i[i] && rdy[i])
                  q[i].push_back('{tag: fu_tag_i[i*TAG_W +: TAG_W], data: fu_data_i[i*XLEN +: XLEN]});
            end
         end
      end

      @(posedge clk);
      #1;
      check("cdb_valid", cdb_valid_o, exp_valid);
      check("cdb_tag", cdb_tag_o, exp_tag);
      check("cdb_data", cdb_data_o, exp_data);
      check("sel_err", sel_err_o, exp_err);
   endtask

   task automatic idle();
      rst = 0; stall_i = 0; flush_i = 0; fu_valid_i = '0; fu_sel = '0;
   endtask

   initial begin
      logic [NUM_FU-1:0] req;
      int                k;
      int                r;

      // 1: reset for two cycles with all FUs presenting results
      idle();
      fu_tag_i = '0; fu_data_i = '0;
      rst = 1; fu_valid_i = '1;
      @(posedge clk);
      #1;
      step();
      idle();
      step();
      check("t1_req_clear", cdb_req, 3'b000);
      check("t1_ready_all", fu_ready_o, 3'b111);

      // 2: single result from FU2
      set_fu(2, 4'h5, 32'hDEAD_BEEF); fu_valid_i = 3'b100;
      step();
      idle(); fu_sel = 3'b100;
      step();
      check("t2_valid", cdb_valid_o, 1'b1);
      check("t2_tag", cdb_tag_o, 4'h5);
      check("t2_data", cdb_data_o, 32'hDEAD_BEEF);
      idle();
      step();

      // 3: FU0 fills, third result dropped, then drains in order
      fu_valid_i = 3'b001;
      for (int t = 1; t <= 3; t++) begin
         set_fu(0, TAG_W'(t), 32'h1000 + t);
         step();
      end
      check("t3_not_ready", fu_ready_o[0], 1'b0);
      idle(); fu_sel = 3'b001;
      step();
      check("t3_first_tag", cdb_tag_o, 4'h1);
      step();
      check("t3_second_tag", cdb_tag_o, 4'h2);
      idle();
      step();

      // 4: one entry in every FU, granted in turn
      set_fu(0, 4'hA, 32'hA0A0_A0A0); set_fu(1, 4'hB, 32'hB1B1_B1B1); set_fu(2, 4'hC, 32'hC2C2_C2C2);
      fu_valid_i = 3'b111;
      step();
      idle();
      check("t4_req_all", cdb_req, 3'b111);
      for (int i = 0; i < NUM_FU; i++) begin
         fu_sel = NUM_FU'(1) << i;
         step();
      end
      idle();
      step();

      // 5: stall blocks the pop, then a bad grant still pops FU1 and flags an error
      set_fu(1, 4'h7, 32'h7777_0001); fu_valid_i = 3'b010;
      step();
      idle(); stall_i = 1; fu_sel = 3'b010;
      step();
      check("t5_stall_err", sel_err_o, 1'b0);
      idle(); fu_sel = 3'b011;
      step();
      check("t5_err_pulse", sel_err_o, 1'b1);
      check("t5_tag", cdb_tag_o, 4'h7);
      idle();
      step();

      // 6: flush with FU1 holding two entries, a grant in flight and an FU0 push
      fu_valid_i = 3'b010;
      set_fu(1, 4'h8, 32'h8888_0001); step();
      set_fu(1, 4'h9, 32'h9999_0002); step();
      idle(); fu_sel = 3'b010;
      step();
      flush_i = 1; fu_valid_i = 3'b001; set_fu(0, 4'hE, 32'hEEEE_EEEE);
      step();
      idle();
      check("t6_req_empty", cdb_req, 3'b000);
      check("t6_ready_all", fu_ready_o, 3'b111);
      step();

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         idle();
         for (int i = 0; i < NUM_FU; i++) set_fu(i, TAG_W'($urandom_range(0, 15)), $urandom);
         fu_valid_i = NUM_FU'($urandom);
         req = model_req();
         r = $urandom_range(0, 99);
         if (r < 60 && req != 0) begin
            do k = $urandom_range(0, NUM_FU - 1); while (!req[k]);
            fu_sel = NUM_FU'(1) << k;
         end else if (r < 85) begin
            fu_sel = NUM_FU'($urandom);
         end
         stall_i = ($urandom_range(0, 99) < 10);
         flush_i = ($urandom_range(0, 99) < 3);
         rst     = ($urandom_range(0, 99) < 1);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/cdb_broadcast.md
Name: cdb_broadcast

Overview:
- Result-staging and broadcast stage for the common data bus, sitting between the functional units and the CDB consumers (reservation stations, ROB, register status).
- Buffers each FU's completed result (tag plus data) in a small per-FU FIFO and raises that FU's cdb_req bit while results are pending.
- Consumes the one-hot fu_sel grant from cdb_arbiter, pops the granted entry and drives it onto the registered CDB outputs.

Parameters:
NUM_FU, 3, number of functional units; sets the width of cdb_req and fu_sel.
XLEN, 32, result data width.
TAG_W, 4, ROB/RS tag width.
DEPTH, 2, entries per FU FIFO; power of two, at least 2.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
stall_i  in  1  global stall; while high, no pops occur.
flush_i  in  1  mispredict flush; discards all buffered results.
fu_valid_i  in  NUM_FU  per-FU result valid.
fu_tag_i  in  NUM_FU*TAG_W  per-FU result tag, packed, FU0 in the LSBs.
fu_data_i  in  NUM_FU*XLEN  per-FU result data, packed, FU0 in the LSBs.
fu_ready_o  out  NUM_FU  per-FU FIFO not full.
cdb_req  out  NUM_FU  per-FU FIFO not empty; drives the arbiter.
fu_sel  in  NUM_FU  one-hot or zero grant from the arbiter, same cycle as cdb_req.
cdb_valid_o  out  1  broadcast valid.
cdb_tag_o  out  TAG_W  broadcast tag.
cdb_data_o  out  XLEN  broadcast data.
sel_err_o  out  1  one-cycle pulse on an illegal grant.

Behaviour:
Reset
- rst is sampled on clk only.
- Clears all FIFO pointers and counts.
- cdb_valid_o=0, cdb_tag_o=0, cdb_data_o=0, sel_err_o=0.
- Outputs from the next cycle: cdb_req=0, fu_ready_o=all ones.
- Reset overrides flush_i, pushes and pops in the same cycle.

Push
- FU i pushes when fu_valid_i[i] && fu_ready_o[i].
- fu_ready_o[i] = count[i] != DEPTH. It depends only on occupancy, so a full FIFO does not accept a push in the cycle it pops.
- A valid presented while not ready is dropped. The FU must hold its result until ready is high.

Request
- cdb_req[i] = count[i] != 0, combinational from registered count.
- No bypass: a result pushed in cycle N raises cdb_req in N+1 at the earliest.

Grant and pop
- Effective grant g = fu_sel & cdb_req when stall_i=0.
- If g has exactly one bit set: that FIFO pops its head. On the next edge, cdb_valid_o=1 and cdb_tag_o/cdb_data_o take the head values. Latency is 1 cycle from grant to broadcast.
- If g = 0: cdb_valid_o=0 next cycle. Tag and data hold their last value.
- If fu_sel is multi-hot, or has a bit set where cdb_req is 0: sel_err_o=1 next cycle. If any granted bit is also requesting, the lowest such index is popped and broadcast normally.
- stall_i=1: no pop, cdb_valid_o=0 next cycle, and sel_err_o is not raised. Pushes still proceed.

Simultaneous events
- Push and pop on the same FIFO in the same cycle: count unchanged, order preserved.
- FIFO pointers wrap modulo DEPTH.

Flush
- flush_i=1 empties every FIFO and sets cdb_valid_o=0 next cycle.
- Pushes in the flush cycle are discarded.
- Flush has priority over push and pop. No partial-flush semantics.

Count width
- count is clog2(DEPTH)+1 bits.
- Never exceeds DEPTH and never underflows. Verification checks both with assertions.

Test Plan:
1. Reset: rst=1 for 2 cycles with fu_valid_i=3'b111 -> after release cdb_req=3'b000, fu_ready_o=3'b111, cdb_valid_o=0.
2. Single result: FU2 pushes tag=4'h5, data=32'hDEAD_BEEF in cycle N -> cdb_req=3'b100 in N+1. fu_sel=3'b100 in N+1 -> cdb_valid_o=1, tag 5, data DEADBEEF in N+2; cdb_req=3'b000 in N+2.
3. Full and backpressure: FU0 pushes tags 1, 2, 3 back-to-back with no grant -> fu_ready_o[0]=0 after 2 pushes; tag 3 is not accepted. Grants then broadcast 1 then 2, in order.
4. Contention: all FUs hold one entry each (cdb_req=3'b111); arbiter grants 3'b001, 3'b010, 3'b100 -> three consecutive broadcasts with the matching tags, then cdb_req=3'b000.
5. Stall and illegal grant: stall_i=1 with fu_sel=3'b010 -> no pop, cdb_valid_o=0, sel_err_o=0. Release stall, then fu_sel=3'b011 while cdb_req=3'b010 -> FU1's head is broadcast and sel_err_o pulses for 1 cycle.
6. Flush mid-operation: with 2 entries in FU1 and a grant in flight, assert flush_i with a concurrent FU0 push -> next cycle cdb_req=3'b000, cdb_valid_o=0, fu_ready_o=3'b111, and the FU0 result is lost.
